// File: rtl/cmp_cal_pkg.sv
// Shared types and constants for the comparator trim calibration slice.
package cmp_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_MEAS,
        ST_WAIT,
        ST_EVAL,
        ST_FINAL
    } cal_state_t;

    localparam int TRIM_W = 4;

    // Signed trim: one sign bit on top of the TRIM_W-bit magnitude.
    typedef logic signed [TRIM_W:0] trim_t;

    function automatic longint unsigned mid_code(input int bits);
        return 64'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/cmp_trim_sweep_ctrl_if.sv
// Handshake between the trim sweep controller and the SAR offset-measurement engine.
interface cmp_trim_sweep_ctrl_if #(
    parameter int BITS = 16
) ();

    logic            meas_start;
    logic            meas_done;
    logic [BITS-1:0] meas_code;

    modport master (
        output meas_start,
        input  meas_done,
        input  meas_code
    );

    modport slave (
        input  meas_start,
        output meas_done,
        output meas_code
    );

endinterface

// File: rtl/cmp_trim_map.sv
// Signed trim code to b_left/b_right magnitude mapper (one comparator).
module cmp_trim_map
    import cmp_cal_pkg::*;
(
    input  trim_t             trim,
    output logic [TRIM_W-1:0] b_left,
    output logic [TRIM_W-1:0] b_right
);

    // Positive trims drive the right leg, negative trims the left leg.
    always_comb begin
        b_left  = '0;
        b_right = '0;
        if (trim[TRIM_W]) begin
            b_left = TRIM_W'(-trim);
        end else if (trim != '0) begin
            b_right = TRIM_W'(trim);
        end
    end

endmodule

// File: rtl/cmp_trim_sweep_ctrl.sv
// Comparator trim sweep: measures every trim in -TRIM_MAX..+TRIM_MAX and applies the best.
// Optional WAIT watchdog enabled by defining MEAS_TIMEOUT_EN.
module cmp_trim_sweep_ctrl
    import cmp_cal_pkg::*;
#(
    parameter int BITS        = 16,
    parameter int TRIM_MAX    = 15,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    cmp_trim_sweep_ctrl_if.master sar,
    output logic [TRIM_W-1:0]     b_left,
    output logic [TRIM_W-1:0]     b_right,
    output logic                  busy,
    output logic                  done,
    output trim_t                 best_trim,
    output logic [BITS-1:0]       best_err,
    output logic                  timeout_err
);

    localparam logic [BITS-1:0] MID         = BITS'(mid_code(BITS));
    localparam trim_t           TRIM_HI     = trim_t'(TRIM_MAX);
    localparam trim_t           TRIM_LO     = trim_t'(-TRIM_MAX);
    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    // An out-of-range configuration never leaves IDLE rather than sweeping garbage codes.
    localparam bit CFG_OK = (BITS >= 2) && (TRIM_MAX >= 1) && (TRIM_MAX <= 15) &&
                            (SETTLE_CYC >= 1) && (SETTLE_CYC <= 255) && (TIMEOUT_CYC >= 1);

    cal_state_t             state;
    cal_state_t             next_state;
    trim_t                  trim;
    logic [7:0]             settle_cnt;
    logic [BITS-1:0]        err_q;
    logic [BITS-1:0]        meas_err;
    logic signed [BITS:0]   diff;
    logic                   accept;
    logic                   abort;

    assign accept = (state == ST_IDLE) && start && CFG_OK;

    always_comb begin
        diff     = $signed({1'b0, sar.meas_code}) - $signed({1'b0, MID});
        meas_err = diff[BITS] ? BITS'(-diff) : BITS'(diff);
    end

`ifdef MEAS_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;

    assign abort = (state == ST_WAIT) && !sar.meas_done &&
                   (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

    // Counts WAIT cycles of the current measurement; sticky error cleared by the next sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_MEAS) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (accept) begin
                timeout_q <= 1'b0;
            end else if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_APPLY;
            ST_APPLY:  next_state = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == 8'd0) next_state = ST_MEAS;
            ST_MEAS:   next_state = ST_WAIT;
            ST_WAIT: begin
                if (sar.meas_done) begin
                    next_state = ST_EVAL;
                end else if (abort) begin
                    next_state = ST_FINAL;
                end
            end
            ST_EVAL:   next_state = (trim == TRIM_HI) ? ST_FINAL : ST_APPLY;
            ST_FINAL:  next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        sar.meas_start = (state == ST_MEAS);
        done           = (state == ST_FINAL);
        busy           = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_MEAS) ||
                         (state == ST_WAIT)  || (state == ST_EVAL);
    end

    // Strict less-than keeps the earlier (more negative) trim on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trim       <= '0;
            settle_cnt <= '0;
            err_q      <= '0;
            best_err   <= '1;
            best_trim  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        trim      <= TRIM_LO;
                        best_err  <= '1;
                        best_trim <= '0;
                    end
                end
                ST_APPLY: settle_cnt <= SETTLE_LOAD;
                ST_SETTLE: begin
                    if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
                end
                ST_WAIT: begin
                    if (sar.meas_done) begin
                        err_q <= meas_err;
                    end else if (abort) begin
                        trim      <= '0;
                        best_trim <= '0;
                        best_err  <= '1;
                    end
                end
                ST_EVAL: begin
                    if (err_q < best_err) begin
                        best_err  <= err_q;
                        best_trim <= trim;
                    end
                    if (trim != TRIM_HI) trim <= trim + trim_t'(1);
                end
                ST_FINAL: trim <= best_trim;
                default: ;
            endcase
        end
    end

    cmp_trim_map u_map (
        .trim    (trim),
        .b_left  (b_left),
        .b_right (b_right)
    );

endmodule

// File: tb/tb_cmp_trim_sweep_ctrl.sv
// Directed bench for cmp_trim_sweep_ctrl with a behavioural SAR stub.
module tb_cmp_trim_sweep_ctrl;

`ifdef MEAS_TIMEOUT_EN
    localparam int TO_CYC = 64;
`else
    localparam int TO_CYC = 4096;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        b_left;
    logic [3:0]        b_right;
    logic              busy;
    logic              done;
    logic signed [4:0] best_trim;
    logic [15:0]       best_err;
    logic              timeout_err;

    logic        stub_done = 1'b0;
    logic [15:0] stub_code = 16'h0000;
    logic        spur_done = 1'b0;
    logic [15:0] spur_code = 16'h0000;
    int          stub_mode = 0;
    int          meas_cnt = 0;
    int          done_cnt = 0;
    int          check_cnt = 0;
    int          pass_cnt = 0;

    cmp_trim_sweep_ctrl_if #(.BITS(16)) sar_if ();

    assign sar_if.meas_done = stub_done | spur_done;
    assign sar_if.meas_code = spur_done ? spur_code : stub_code;

    cmp_trim_sweep_ctrl #(
        .BITS(16), .TRIM_MAX(15), .SETTLE_CYC(2), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sar         (sar_if.master),
        .b_left      (b_left),
        .b_right     (b_right),
        .busy        (busy),
        .done        (done),
        .best_trim   (best_trim),
        .best_err    (best_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sar_if.meas_start === 1'b1) meas_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // SAR stub: answers five cycles after meas_start using the trim the comparator sees.
    always @(negedge clk) begin
        int t;
        int code;
        if (sar_if.meas_start === 1'b1 && stub_mode != 2) begin
            t = (b_right != 4'd0) ? int'(b_right) : -int'(b_left);
            if (stub_mode == 0) code = 32768 + 200 * (t - 3);
            else                code = 32768 + 50 * (t * t - 4);
            repeat (5) @(posedge clk);
            #1 stub_code = 16'(code);
            stub_done = 1'b1;
            @(posedge clk);
            #1 stub_done = 1'b0;
        end
    end

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_for_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_cnt++; if (b_left !== 4'd0) $display("[TB] FAIL reset b_left got %0d want 0", b_left); else pass_cnt++;
        check_cnt++; if (b_right !== 4'd0) $display("[TB] FAIL reset b_right got %0d want 0", b_right); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset busy got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (done !== 1'b0) $display("[TB] FAIL reset done got %b want 0", done); else pass_cnt++;
        check_cnt++; if (sar_if.meas_start !== 1'b0) $display("[TB] FAIL reset meas_start got %b want 0", sar_if.meas_start); else pass_cnt++;
        check_cnt++; if (best_trim !== 5'sd0) $display("[TB] FAIL reset best_trim got %0d want 0", best_trim); else pass_cnt++;
        check_cnt++; if (best_err !== 16'hFFFF) $display("[TB] FAIL reset best_err got %h want ffff", best_err); else pass_cnt++;
        check_cnt++; if (timeout_err !== 1'b0) $display("[TB] FAIL reset timeout_err got %b want 0", timeout_err); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_cnt++; if (busy !== 1'b0 || sar_if.meas_start !== 1'b0)
            $display("[TB] FAIL post_reset idle busy=%b meas_start=%b want 0/0", busy, sar_if.meas_start); else pass_cnt++;
    endtask

    task automatic test_linear();
        int mbase;
        int dbase;
        bit seen;
        stub_mode = 0;
        mbase = meas_cnt;
        dbase = done_cnt;
        start_pulse();
        wait_for_done(1000, seen);
        check_cnt++; if (!seen) $display("[TB] FAIL lin done_seen got 0 want 1"); else pass_cnt++;
        check_cnt++; if (best_trim !== 5'sd3) $display("[TB] FAIL lin best_trim got %0d want 3", best_trim); else pass_cnt++;
        check_cnt++; if (best_err !== 16'd0) $display("[TB] FAIL lin best_err got %0d want 0", best_err); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (b_right !== 4'd3 || b_left !== 4'd0)
            $display("[TB] FAIL lin trims got L=%0d R=%0d want L=0 R=3", b_left, b_right); else pass_cnt++;
        repeat (3) @(negedge clk);
        check_cnt++; if (meas_cnt - mbase != 31) $display("[TB] FAIL lin meas_count got %0d want 31", meas_cnt - mbase); else pass_cnt++;
        check_cnt++; if (done_cnt - dbase != 1) $display("[TB] FAIL lin done_count got %0d want 1", done_cnt - dbase); else pass_cnt++;
    endtask

    task automatic test_tie();
        bit seen;
        stub_mode = 1;
        start_pulse();
        wait_for_done(1000, seen);
        check_cnt++; if (!seen) $display("[TB] FAIL tie done_seen got 0 want 1"); else pass_cnt++;
        check_cnt++; if (best_trim !== -5'sd2) $display("[TB] FAIL tie best_trim got %0d want -2", best_trim); else pass_cnt++;
        check_cnt++; if (best_err !== 16'd0) $display("[TB] FAIL tie best_err got %0d want 0", best_err); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (b_left !== 4'd2 || b_right !== 4'd0)
            $display("[TB] FAIL tie trims got L=%0d R=%0d want L=2 R=0", b_left, b_right); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int mbase;
        int dbase;
        int mafter;
        bit seen;
        bit busy_seen;
        stub_mode = 0;
        mbase = meas_cnt;
        dbase = done_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        spur_code = 16'h8000;
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        wait_for_done(1000, seen);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        mafter = meas_cnt;
        busy_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        check_cnt++; if (!seen) $display("[TB] FAIL b2b done_seen got 0 want 1"); else pass_cnt++;
        check_cnt++; if (best_trim !== 5'sd3) $display("[TB] FAIL b2b best_trim got %0d want 3", best_trim); else pass_cnt++;
        check_cnt++; if (meas_cnt - mbase != 31) $display("[TB] FAIL b2b meas_count got %0d want 31", meas_cnt - mbase); else pass_cnt++;
        check_cnt++; if (done_cnt - dbase != 1) $display("[TB] FAIL b2b done_count got %0d want 1", done_cnt - dbase); else pass_cnt++;
        check_cnt++; if (busy_seen || meas_cnt != mafter)
            $display("[TB] FAIL b2b start_at_done busy_seen=%b new_meas=%0d want 0/0", busy_seen, meas_cnt - mafter); else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        bit seen;
        stub_mode = 0;
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sar_if.meas_start === 1'b1 && b_left == 4'd0 && b_right == 4'd0) begin
                found = 1'b1;
                break;
            end
        end
        check_cnt++; if (!found) $display("[TB] FAIL mid t0_meas_found got 0 want 1"); else pass_cnt++;
        @(posedge clk);
        #2;
        check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL mid busy_in_wait got %b want 1", busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        check_cnt++; if (b_left !== 4'd0 || b_right !== 4'd0 || busy !== 1'b0)
            $display("[TB] FAIL mid async_reset got L=%0d R=%0d busy=%b want 0/0/0", b_left, b_right, busy); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        start_pulse();
        @(negedge clk);
        check_cnt++; if (b_left !== 4'd15 || b_right !== 4'd0)
            $display("[TB] FAIL mid restart_trim got L=%0d R=%0d want L=15 R=0", b_left, b_right); else pass_cnt++;
        wait_for_done(1000, seen);
        check_cnt++; if (!seen || best_trim !== 5'sd3)
            $display("[TB] FAIL mid restart_result seen=%b best_trim=%0d want 1/3", seen, best_trim); else pass_cnt++;
    endtask

`ifdef MEAS_TIMEOUT_EN
    task automatic test_timeout();
        bit found;
        int n;
        stub_mode = 2;
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sar_if.meas_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n = 0;
        while (found && n < 200) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
        end
        check_cnt++; if (!found || n != 65)
            $display("[TB] FAIL to done_latency got found=%b n=%0d want 1/65", found, n); else pass_cnt++;
        check_cnt++; if (timeout_err !== 1'b1) $display("[TB] FAIL to timeout_err got %b want 1", timeout_err); else pass_cnt++;
        check_cnt++; if (best_trim !== 5'sd0) $display("[TB] FAIL to best_trim got %0d want 0", best_trim); else pass_cnt++;
        check_cnt++; if (best_err !== 16'hFFFF) $display("[TB] FAIL to best_err got %h want ffff", best_err); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (b_left !== 4'd0 || b_right !== 4'd0 || timeout_err !== 1'b1)
            $display("[TB] FAIL to idle got L=%0d R=%0d terr=%b want 0/0/1", b_left, b_right, timeout_err); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_linear();
        test_tie();
        test_back_to_back();
        test_reset_mid_sweep();
`ifdef MEAS_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/cmp_trim_sweep_ctrl.md
Name: cmp_trim_sweep_ctrl

Overview:
Calibration sequencer that sits directly upstream of the comparator trim inputs and downstream of the SAR offset-measurement engine. It sweeps the signed trim code from -15 to +15 and drives b_left/b_right for each step. For each step it requests one SAR measurement and collects the resulting DAC code. It keeps the trim whose code is closest to mid-scale, then applies that trim and reports done.

Parameters:
BITS, 16, SAR DAC code width (meas_code).
TRIM_MAX, 15, sweep magnitude; the sweep runs -TRIM_MAX..+TRIM_MAX, and the value must fit in 4 bits.
SETTLE_CYC, 2, cycles to wait after a trim change before starting a measurement (1..255).
TIMEOUT_CYC, 4096, maximum WAIT cycles per measurement; used only with MEAS_TIMEOUT_EN.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that starts a sweep; ignored unless in IDLE.
meas_start  out  1  one-cycle request to the SAR engine.
meas_done  in  1  one-cycle pulse from the SAR; meas_code is valid in the same cycle.
meas_code  in  BITS  final SAR DAC code.
b_left  out  4  negative trim magnitude.
b_right  out  4  positive trim magnitude.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when the best trim has been applied.
best_trim  out  5  signed two's-complement best trim.
best_err  out  BITS  |meas_code - 2^(BITS-1)| at best_trim.
timeout_err  out  1  sticky until next start; tied 0 when the macro is absent.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0. best_err resets to all-ones.
- Trim mapping (combinational from the registered trim t):
  - t>0: b_right=t, b_left=0.
  - t<0: b_left=-t, b_right=0.
  - t=0: both outputs 0.
- States: IDLE, APPLY, SETTLE, MEAS, WAIT, EVAL, FINAL.
- IDLE: on start:
  - t=-TRIM_MAX, best_err=all-ones, best_trim=0, timeout_err=0.
  - Go to APPLY.
- APPLY (1 cycle): b_left/b_right show t; the settle counter is loaded.
- SETTLE: lasts SETTLE_CYC cycles, then MEAS.
- MEAS (1 cycle): meas_start=1; go to WAIT.
- WAIT: holds until meas_done=1.
  - Latch err=|meas_code - 2^(BITS-1)|, computed with a BITS+1-bit signed subtract, then abs, truncated to BITS.
  - Go to EVAL.
  - meas_done in any state other than WAIT is ignored.
- EVAL (1 cycle):
  - If err < best_err (strict), update best_err and best_trim=t. On a tie the earlier, more negative trim wins.
  - If t==+TRIM_MAX, go to FINAL; else t=t+1 and go to APPLY.
  - No wrap; the sweep always covers all 2*TRIM_MAX+1 points.
- FINAL (1 cycle):
  - t=best_trim, so b_left/b_right are driven by best_trim from the next cycle.
  - done=1; busy drops the same cycle; go to IDLE.
  - The trim outputs hold best_trim in IDLE until the next start or reset.
- Per-step latency = 1 + SETTLE_CYC + 1 + (WAIT cycles) + 1.
- start while busy: ignored, no restart.
- start in the same cycle as the FINAL done pulse: ignored. It is accepted from the next cycle.

Optional Feature:
MEAS_TIMEOUT_EN:
- Defined:
  - A WAIT-cycle counter runs. If it reaches TIMEOUT_CYC without meas_done, abort.
  - On abort: timeout_err=1, t forced to 0, best_trim=0, best_err=all-ones, go to FINAL. done pulses; trims become 0.
- Undefined: no counter; WAIT waits indefinitely; timeout_err is constant 0.

Decomposition:
- Package cmp_cal_pkg holds:
  - the state enum;
  - localparam MID = 2^(BITS-1) helper function;
  - the TRIM_W=4 constant;
  - the signed trim type (5 bits).
- One natural sub-module: cmp_trim_map, the combinational signed-trim to b_left/b_right mapper. It is reused by any future per-comparator trim bank.

Test Plan:
1. Reset behaviour: assert rst_n=0 mid-IDLE, then release -> all outputs 0, best_err=16'hFFFF, no meas_start.
2. Linear offset: SAR stub returns meas_code=16'h8000+200*(t-3), meas_done 5 cycles after meas_start -> 31 meas_start pulses; best_trim=+3, b_right=3, b_left=0, best_err=0, one done pulse.
3. Tie: stub returns 16'h8000+50*(t*t-4) -> ±2 both give err 0; best_trim=-2, b_left=2, b_right=0.
4. Protocol robustness: start pulsed during SETTLE, spurious meas_done during SETTLE, start in the same cycle as done -> none alter the sequence; exactly 31 measurements; done once.
5. Reset mid-sweep: pull rst_n low while in WAIT at t=0 -> b_left/b_right/busy go 0 asynchronously. A new start restarts at t=-15 (b_left=15 after APPLY).
6. With MEAS_TIMEOUT_EN, TIMEOUT_CYC=64: stub never asserts meas_done -> 64 WAIT cycles after the first meas_start, done=1, timeout_err=1, best_trim=0, b_left=b_right=0.
